// File: rtl/decode_stage.sv
// decode_stage: IF/ID register with stall/flush, MIPS-subset decoder,
// 32x32 register file with write-through bypass, and a sticky flag
// for undecodable instructions. Next-PC controls return to the fetcher.
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        WbRegWrite,
  input  logic [4:0]  WbReg,
  input  logic [31:0] WbData,
  output logic [15:0] imm16,
  output logic [25:0] target,
  output logic [4:0]  Rd,
  output logic [31:0] BusA,
  output logic [31:0] BusB,
  output logic        BranchSignal,
  output logic        Jump,
  output logic        BranchCondition,
  output logic        RegDst,
  output logic        ALUSrc,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        ExtOp,
  output logic [2:0]  ALUCtr,
  output logic        Valid,
  output logic        Illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_LUI  = 3'b100;

  logic [31:0] r_instr_p0;
  logic        r_vld_p0;
  logic        r_illegal;
  logic [31:0] r_regs [0:31];

  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic        w_legal;
  logic        w_en;
  logic        w_wb_hit;

  logic        w_regdst;
  logic        w_alusrc;
  logic        w_memtoreg;
  logic        w_regwrite;
  logic        w_memwrite;
  logic        w_extop;
  logic        w_branch;
  logic        w_jump;
  logic [2:0]  w_aluctr;

  // ---- stage p0: IF/ID register (reset > flush > stall > load)
  always_ff @(posedge clk) begin
    if (rst || Flush) begin
      r_instr_p0 <= 32'd0;
      r_vld_p0   <= 1'b0;
    end else if (!Stall) begin
      r_instr_p0 <= instruction;
      r_vld_p0   <= 1'b1;
    end
  end

  assign w_op = r_instr_p0[31:26];
  assign w_fn = r_instr_p0[5:0];
  assign w_rs = r_instr_p0[25:21];
  assign w_rt = r_instr_p0[20:16];
  assign w_rd = r_instr_p0[15:11];

  // Raw decode of the held word; w_legal is low for anything outside the subset
  always_comb begin
    w_regdst   = 1'b0;
    w_alusrc   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_memwrite = 1'b0;
    w_extop    = 1'b0;
    w_branch   = 1'b0;
    w_jump     = 1'b0;
    w_aluctr   = ALU_ADD;
    w_legal    = 1'b1;
    if (r_instr_p0 == 32'd0) begin
      w_legal = 1'b1;
    end else begin
      case (w_op)
        OP_RTYPE: begin
          case (w_fn)
            FN_ADDU: begin w_regdst = 1'b1; w_regwrite = 1'b1; w_aluctr = ALU_ADD; end
            FN_SUBU: begin w_regdst = 1'b1; w_regwrite = 1'b1; w_aluctr = ALU_SUB; end
            FN_SLT:  begin w_regdst = 1'b1; w_regwrite = 1'b1; w_aluctr = ALU_SLT; end
            default: w_legal = 1'b0;
          endcase
        end
        OP_ORI: begin w_alusrc = 1'b1; w_regwrite = 1'b1; w_aluctr = ALU_OR; end
        OP_LUI: begin w_alusrc = 1'b1; w_regwrite = 1'b1; w_aluctr = ALU_LUI; end
        OP_LW: begin
          w_alusrc = 1'b1; w_memtoreg = 1'b1; w_regwrite = 1'b1; w_extop = 1'b1;
          w_aluctr = ALU_ADD;
        end
        OP_SW: begin w_alusrc = 1'b1; w_memwrite = 1'b1; w_extop = 1'b1; w_aluctr = ALU_ADD; end
        OP_BEQ: begin w_branch = 1'b1; w_aluctr = ALU_SUB; end
        OP_J:   w_jump = 1'b1;
        default: w_legal = 1'b0;
      endcase
    end
  end

  // Bubbles and undecodable words must not drive any datapath or next-PC action
  assign w_en = r_vld_p0 & w_legal;

  assign RegDst       = w_en & w_regdst;
  assign ALUSrc       = w_en & w_alusrc;
  assign MemToReg     = w_en & w_memtoreg;
  assign RegWrite     = w_en & w_regwrite;
  assign MemWrite     = w_en & w_memwrite;
  assign ExtOp        = w_en & w_extop;
  assign BranchSignal = w_en & w_branch;
  assign Jump         = w_en & w_jump;
  assign ALUCtr       = w_en ? w_aluctr : 3'b000;

  assign imm16  = r_instr_p0[15:0];
  assign target = r_instr_p0[25:0];
  assign Rd     = RegDst ? w_rd : w_rt;
  assign Valid  = r_vld_p0;

  // Sticky flag: once an undecodable word is seen valid, only reset clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_illegal <= 1'b0;
    end else if (r_vld_p0 && !w_legal) begin
      r_illegal <= 1'b1;
    end
  end

  assign Illegal = r_illegal;

  // Register file write; independent of Stall/Flush so writeback is never lost
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (WbRegWrite && (WbReg != 5'd0)) begin
      r_regs[WbReg] <= WbData;
    end
  end

  // Same-cycle writeback is forwarded so a consumer never sees a stale value
  assign w_wb_hit = WbRegWrite && (WbReg != 5'd0);

  assign BusA = (w_rs == 5'd0) ? 32'd0 :
                (w_wb_hit && (WbReg == w_rs)) ? WbData : r_regs[w_rs];
  assign BusB = (w_rt == 5'd0) ? 32'd0 :
                (w_wb_hit && (WbReg == w_rt)) ? WbData : r_regs[w_rt];

  assign BranchCondition = (BusA == BusB);

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes expected values tagged
// with the cycle they must appear in; a monitor pops and compares them.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic        Stall;
  logic        Flush;
  logic        WbRegWrite;
  logic [4:0]  WbReg;
  logic [31:0] WbData;
  logic [15:0] imm16;
  logic [25:0] target;
  logic [4:0]  Rd;
  logic [31:0] BusA;
  logic [31:0] BusB;
  logic        BranchSignal;
  logic        Jump;
  logic        BranchCondition;
  logic        RegDst;
  logic        ALUSrc;
  logic        MemToReg;
  logic        RegWrite;
  logic        MemWrite;
  logic        ExtOp;
  logic [2:0]  ALUCtr;
  logic        Valid;
  logic        Illegal;

  decode_stage dut (
    .clk(clk), .rst(rst), .instruction(instruction), .Stall(Stall), .Flush(Flush),
    .WbRegWrite(WbRegWrite), .WbReg(WbReg), .WbData(WbData),
    .imm16(imm16), .target(target), .Rd(Rd), .BusA(BusA), .BusB(BusB),
    .BranchSignal(BranchSignal), .Jump(Jump), .BranchCondition(BranchCondition),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .ExtOp(ExtOp), .ALUCtr(ALUCtr), .Valid(Valid), .Illegal(Illegal)
  );

  localparam int F_VALID = 0;
  localparam int F_ILL   = 1;
  localparam int F_CTRL  = 2;
  localparam int F_BUSA  = 3;
  localparam int F_BUSB  = 4;
  localparam int F_BC    = 5;
  localparam int F_RD    = 6;
  localparam int F_IMM   = 7;
  localparam int F_TGT   = 8;

  localparam logic [31:0] I_ADDU = 32'h00221821;
  localparam logic [31:0] I_LW   = 32'h8C010004;
  localparam logic [31:0] I_J    = 32'h08000010;
  localparam logic [31:0] I_BEQ  = 32'h10220003;
  localparam logic [31:0] I_RS5  = 32'h00A00021;
  localparam logic [31:0] I_BAD  = 32'hFC000000;

  // Control bundle order: {Branch, Jump, RegDst, ALUSrc, MemToReg, RegWrite, MemWrite, ExtOp, ALUCtr[2:0]}
  localparam logic [31:0] C_NONE = 32'b000_0000_0000;
  localparam logic [31:0] C_ADDU = 32'b001_0010_0000;
  localparam logic [31:0] C_LW   = 32'b000_1110_1000;
  localparam logic [31:0] C_J    = 32'b010_0000_0000;
  localparam logic [31:0] C_BEQ  = 32'b100_0000_0001;

  typedef struct {
    int          cyc;
    string       nm;
    int          f;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int f);
    case (f)
      F_VALID: actual = {31'd0, Valid};
      F_ILL:   actual = {31'd0, Illegal};
      F_CTRL:  actual = {21'd0, BranchSignal, Jump, RegDst, ALUSrc, MemToReg,
                         RegWrite, MemWrite, ExtOp, ALUCtr};
      F_BUSA:  actual = BusA;
      F_BUSB:  actual = BusB;
      F_BC:    actual = {31'd0, BranchCondition};
      F_RD:    actual = {27'd0, Rd};
      F_IMM:   actual = {16'd0, imm16};
      F_TGT:   actual = {6'd0, target};
      default: actual = 32'hxxxxxxxx;
    endcase
  endfunction

  // Monitor: compare every expectation due in this cycle, away from the rising edge
  always @(negedge clk) begin
    exp_t it;
    logic [31:0] a;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      it = sb.pop_front();
      a = actual(it.f);
      checks++;
      if (it.cyc != cyc || a !== it.v) begin
        errors++;
        $display("FAIL %s cyc=%0d got=%h expected=%h", it.nm, it.cyc, a, it.v);
      end
    end
  end

  task automatic expect_at(input int c, input string nm, input int f, input logic [31:0] v);
    exp_t e;
    e.cyc = c; e.nm = nm; e.f = f; e.v = v;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0;
    rst = 1'b1; instruction = I_LW; Stall = 1'b0; Flush = 1'b0;
    WbRegWrite = 1'b0; WbReg = 5'd0; WbData = 32'd0;

    // Reset held two cycles
    step(); step();
    expect_at(cyc, "rst_valid", F_VALID, 32'd0);
    expect_at(cyc, "rst_ctrl",  F_CTRL,  C_NONE);
    expect_at(cyc, "rst_busa",  F_BUSA,  32'd0);
    expect_at(cyc, "rst_busb",  F_BUSB,  32'd0);
    expect_at(cyc, "rst_ill",   F_ILL,   32'd0);
    expect_at(cyc, "rst_bc",    F_BC,    32'd1);
    expect_at(cyc, "rst_rd",    F_RD,    32'd0);
    expect_at(cyc, "rst_imm",   F_IMM,   32'd0);
    expect_at(cyc, "rst_tgt",   F_TGT,   32'd0);
    rst = 1'b0; instruction = I_ADDU;

    // Decode sweep
    step();
    expect_at(cyc, "addu_valid", F_VALID, 32'd1);
    expect_at(cyc, "addu_ctrl",  F_CTRL,  C_ADDU);
    expect_at(cyc, "addu_rd",    F_RD,    32'd3);
    instruction = I_LW;
    step();
    expect_at(cyc, "lw_ctrl", F_CTRL, C_LW);
    expect_at(cyc, "lw_rd",   F_RD,   32'd1);
    expect_at(cyc, "lw_imm",  F_IMM,  32'h0004);
    instruction = I_J;
    step();
    expect_at(cyc, "j_ctrl", F_CTRL, C_J);
    expect_at(cyc, "j_tgt",  F_TGT,  32'h0000010);
    instruction = I_RS5;

    // Writeback bypass and r0 protection
    step();
    WbRegWrite = 1'b1; WbReg = 5'd5; WbData = 32'hDEADBEEF;
    expect_at(cyc, "bypass_busa", F_BUSA, 32'hDEADBEEF);
    step();
    WbReg = 5'd0; WbData = 32'h00001234;
    expect_at(cyc, "array_busa", F_BUSA, 32'hDEADBEEF);
    expect_at(cyc, "r0_bypass",  F_BUSB, 32'd0);
    step();
    WbRegWrite = 1'b0;
    expect_at(cyc, "r0_array", F_BUSB, 32'd0);

    // Branch compare on bypassed and stored operands
    WbRegWrite = 1'b1; WbReg = 5'd1; WbData = 32'd7; instruction = I_BEQ;
    step();
    WbReg = 5'd2; WbData = 32'd7;
    expect_at(cyc, "beq_ctrl", F_CTRL, C_BEQ);
    expect_at(cyc, "beq_eq",   F_BC,   32'd1);
    step();
    WbReg = 5'd2; WbData = 32'd8;
    expect_at(cyc, "beq_ne_bypass", F_BC, 32'd0);
    step();
    WbRegWrite = 1'b0;
    expect_at(cyc, "beq_ne_array", F_BC,   32'd0);
    expect_at(cyc, "r2_array",     F_BUSB, 32'd8);
    instruction = I_ADDU;

    // Stall holds, then stall+flush gives a bubble
    step();
    expect_at(cyc, "pre_stall_ctrl", F_CTRL, C_ADDU);
    expect_at(cyc, "pre_stall_busa", F_BUSA, 32'd7);
    Stall = 1'b1; instruction = I_LW;
    for (int k = 0; k < 3; k++) begin
      step();
      instruction = (k == 0) ? I_J : I_BEQ;
      expect_at(cyc, "stall_valid", F_VALID, 32'd1);
      expect_at(cyc, "stall_ctrl",  F_CTRL,  C_ADDU);
      expect_at(cyc, "stall_rd",    F_RD,    32'd3);
    end
    Flush = 1'b1;
    step();
    Stall = 1'b0; Flush = 1'b0;
    expect_at(cyc, "flush_valid", F_VALID, 32'd0);
    expect_at(cyc, "flush_ctrl",  F_CTRL,  C_NONE);
    instruction = I_BAD;

    // Illegal instruction and stickiness
    step();
    expect_at(cyc, "bad_valid", F_VALID, 32'd1);
    expect_at(cyc, "bad_ctrl",  F_CTRL,  C_NONE);
    instruction = I_ADDU;
    step();
    expect_at(cyc, "ill_set",      F_ILL,  32'd1);
    expect_at(cyc, "ill_next_ctl", F_CTRL, C_ADDU);
    instruction = I_LW;
    step();
    expect_at(cyc, "ill_sticky", F_ILL,  32'd1);
    expect_at(cyc, "ill_lw_ctl", F_CTRL, C_LW);
    rst = 1'b1;
    step();
    rst = 1'b0; instruction = I_BEQ;
    expect_at(cyc, "ill_clear",  F_ILL,   32'd0);
    expect_at(cyc, "rst2_valid", F_VALID, 32'd0);

    // Reset cleared the register file
    step();
    expect_at(cyc, "rst2_busa", F_BUSA, 32'd0);
    expect_at(cyc, "rst2_busb", F_BUSB, 32'd0);
    expect_at(cyc, "rst2_bc",   F_BC,   32'd1);
    expect_at(cyc, "rst2_ctrl", F_CTRL, C_BEQ);

    step(); step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound so the run always terminates
  initial begin
    #20000;
    $display("FAIL timeout cyc=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
